// File: rtl/az_seq_pkg.sv
// Shared definitions for the auto-zero scan sequencer: FSM state encoding,
// mux value width, table word field layout and named mux constants.
package az_seq_pkg;

    // Width of each auto-zero mux select value
    localparam int MUX_W = 4;

    // Table word layout: {hi[3:0], lo[3:0], cycles[CYC_W-1:0]}.
    // The mux fields sit above the cycle count, so their offsets are
    // relative to CYC_W.
    localparam int HDR_W  = 2 * MUX_W;
    localparam int LO_OFS = 0;
    localparam int HI_OFS = MUX_W;

    // Mux setting that selects input S1
    localparam logic [MUX_W-1:0] AZMUX_S1 = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MODRST = 3'd2,
        ST_RUN    = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/az_seq_table.sv
// Scan table register file: NUM_ENTRY words, one synchronous write port,
// one asynchronous read port. Contents are not reset.
module az_seq_table
    import az_seq_pkg::*;
#(
    parameter int NUM_ENTRY = 8,
    parameter int ENT_W     = HDR_W + 8,
    localparam int ADDR_W   = $clog2(NUM_ENTRY)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ENT_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ENT_W-1:0]  rd_data
);

    logic [ENT_W-1:0] mem [NUM_ENTRY];

    // Write port: storage only, no reset on table contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/az_scan_sequencer.sv
// Auto-zero scan sequencer: walks a table of mux configurations, restarts
// the modulator on each entry and lets it run a programmed number of AZ
// cycles before advancing. One-shot or continuous scan.
// Optional watchdog on az_cycle_done spacing: define AZ_SEQ_WATCHDOG_EN.
module az_scan_sequencer
    import az_seq_pkg::*;
#(
    parameter int NUM_ENTRY    = 8,
    parameter int CYC_W        = 8,
    parameter int MOD_RST_CLKS = 4,
    parameter int WDOG_CLKS    = 2**26,
    localparam int ADDR_W      = $clog2(NUM_ENTRY)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tbl_wr,
    input  logic [ADDR_W-1:0]      tbl_addr,
    input  logic [HDR_W+CYC_W-1:0] tbl_data,
    input  logic [ADDR_W:0]        num_entry,
    input  logic                   continuous,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   az_cycle_done,
    output logic                   mod_reset,
    output logic [MUX_W-1:0]       azmux_lo_val,
    output logic [MUX_W-1:0]       azmux_hi_val,
    output logic [ADDR_W-1:0]      cur_entry,
    output logic                   busy,
    output logic                   entry_done,
    output logic                   scan_done,
    output logic                   err
);

    localparam int ENT_W     = HDR_W + CYC_W;
    localparam int RST_CNT_W = (MOD_RST_CLKS > 1) ? $clog2(MOD_RST_CLKS) : 1;

    localparam logic [ADDR_W:0]      NUM_LIM   = (ADDR_W+1)'(NUM_ENTRY);
    localparam logic [ADDR_W:0]      LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]    ADDR_ONE  = ADDR_W'(1);
    localparam logic [CYC_W-1:0]     CYC_ONE   = CYC_W'(1);
    localparam logic [RST_CNT_W-1:0] RST_ONE   = RST_CNT_W'(1);
    localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(MOD_RST_CLKS - 1);

    // Reject parameter sets the counters and address math cannot support
    if (MOD_RST_CLKS < 1 || NUM_ENTRY < 2 || (NUM_ENTRY & (NUM_ENTRY - 1)) != 0
        || WDOG_CLKS < 1) begin : g_bad_param
        $error("az_scan_sequencer: unsupported parameter set");
    end

    state_t                 state;
    logic [CYC_W-1:0]       cyc_cnt;
    logic [RST_CNT_W-1:0]   rst_cnt;
    logic [ADDR_W:0]        scan_len;
    logic [ENT_W-1:0]       rd_entry;
    logic [CYC_W-1:0]       rd_cycles;
    logic [ADDR_W:0]        num_clamped;
    logic                   tbl_we;
    logic                   last_entry;

`ifdef AZ_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CLKS + 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CLKS - 1);
    logic [WDOG_W-1:0] wdog_cnt;
`endif

    // Table writes are only accepted while idle so a running scan never
    // sees its entries change underneath it.
    assign tbl_we      = tbl_wr && (state == ST_IDLE);
    assign rd_cycles   = rd_entry[CYC_W-1:0];
    assign num_clamped = (num_entry > NUM_LIM) ? NUM_LIM : num_entry;
    assign last_entry  = ({1'b0, cur_entry} == (scan_len - LEN_ONE));

    az_seq_table #(
        .NUM_ENTRY (NUM_ENTRY),
        .ENT_W     (ENT_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (tbl_we),
        .wr_addr (tbl_addr),
        .wr_data (tbl_data),
        .rd_addr (cur_entry),
        .rd_data (rd_entry)
    );

    // Scan FSM with counters and registered modulator/status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mod_reset    <= 1'b1;
            azmux_lo_val <= '0;
            azmux_hi_val <= '0;
            cur_entry    <= '0;
            busy         <= 1'b0;
            entry_done   <= 1'b0;
            scan_done    <= 1'b0;
            err          <= 1'b0;
            cyc_cnt      <= '0;
            rst_cnt      <= '0;
            scan_len     <= '0;
`ifdef AZ_SEQ_WATCHDOG_EN
            wdog_cnt     <= '0;
`endif
        end else begin
            entry_done <= 1'b0;
            scan_done  <= 1'b0;

            // A table write attempted mid-scan is dropped and flagged
            if (tbl_wr && state != ST_IDLE) begin
                err <= 1'b1;
            end

            if (stop && state != ST_IDLE) begin
                // Abort wins over everything, including a completing AZ cycle
                state     <= ST_IDLE;
                mod_reset <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        mod_reset <= 1'b1;
                        if (start && !stop) begin
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            scan_len <= num_clamped;
                            if (num_clamped == '0) begin
                                state <= ST_DONE;
                            end else begin
                                cur_entry <= '0;
                                state     <= ST_LOAD;
                            end
                        end
                    end

                    ST_LOAD: begin
                        azmux_lo_val <= rd_entry[CYC_W+LO_OFS +: MUX_W];
                        azmux_hi_val <= rd_entry[CYC_W+HI_OFS +: MUX_W];
                        cyc_cnt      <= rd_cycles;
                        rst_cnt      <= '0;
                        // Zero-cycle entries are skipped without touching the modulator
                        state        <= (rd_cycles == '0) ? ST_NEXT : ST_MODRST;
                    end

                    ST_MODRST: begin
                        if (rst_cnt == RST_LAST) begin
                            mod_reset <= 1'b0;
                            state     <= ST_RUN;
`ifdef AZ_SEQ_WATCHDOG_EN
                            wdog_cnt  <= '0;
`endif
                        end else begin
                            rst_cnt <= rst_cnt + RST_ONE;
                        end
                    end

                    ST_RUN: begin
                        if (az_cycle_done) begin
`ifdef AZ_SEQ_WATCHDOG_EN
                            wdog_cnt <= '0;
`endif
                            if (cyc_cnt == CYC_ONE) begin
                                cyc_cnt    <= '0;
                                entry_done <= 1'b1;
                                state      <= ST_NEXT;
                            end else begin
                                cyc_cnt <= cyc_cnt - CYC_ONE;
                            end
                        end
`ifdef AZ_SEQ_WATCHDOG_EN
                        else if (wdog_cnt == WDOG_LAST) begin
                            // Modulator went silent: abandon the scan
                            err       <= 1'b1;
                            mod_reset <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            wdog_cnt <= wdog_cnt + WDOG_ONE;
                        end
`endif
                    end

                    ST_NEXT: begin
                        mod_reset <= 1'b1;
                        if (last_entry) begin
                            if (continuous) begin
                                cur_entry <= '0;
                                state     <= ST_LOAD;
                            end else begin
                                state <= ST_DONE;
                            end
                        end else begin
                            cur_entry <= cur_entry + ADDR_ONE;
                            state     <= ST_LOAD;
                        end
                    end

                    ST_DONE: begin
                        scan_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end

                    default: begin
                        mod_reset <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
